// File: rtl/hc_mmio_rd_responder.sv
// ---------------------------------------------------------------------------
// hc_mmio_rd_responder
//   CCI-P MMIO read responder for HardCloud AFUs. Returns the AFU DFH, the
//   AFU GUID and read-back copies of the HC DSM/control/buffer registers.
//   The register values come from the write-decode register file next to it.
//   The pipeline has two fixed stages, so the latency is exactly two cycles.
//   It accepts one request per cycle, and c2 has no backpressure.
//
//   Ports:
//     clk, rst_n        AFU clock, asynchronous active-low reset
//     rx_mmio_channel   c0 Rx; mmioRdValid + hdr (MMIO request header)
//     tx_mmio_channel   c2 Tx; mmioRdValid, hdr.tid, data[63:0]
//     hc_dsm_base       DSM base register value
//     hc_control        control register value
//     hc_buffer         packed t_hc_buffer array, entry i at [96*i +: 96]
//     hc_status         {error, done}
//     rd_err            sticky flag: a read with length 2/3 was accepted
//
//   Optional build macro:
//     HC_MMIO_RD_CNT_EN  adds a 32-bit response counter, readable at 0x108
// ---------------------------------------------------------------------------
package hc_mmio_rd_pkg;
  typedef struct packed {
    logic [15:0] address;   // 4-byte word address
    logic [1:0]  length;    // 0: 4B, 1: 8B, 2/3: unsupported
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] size;
  } t_hc_buffer;
endpackage

module hc_mmio_rd_responder
  import hc_mmio_rd_pkg::*;
#(
  parameter logic [63:0]  AFU_DFH        = 64'h1000_0100_0000_0000,
  parameter logic [127:0] AFU_ID         = 128'h0,
  parameter int           HC_BUFFER_SIZE = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  t_if_ccip_c0_Rx                rx_mmio_channel,
  output t_if_ccip_c2_Tx                tx_mmio_channel,
  input  logic [63:0]                   hc_dsm_base,
  input  logic [31:0]                   hc_control,
  input  logic [HC_BUFFER_SIZE*96-1:0]  hc_buffer,
  input  logic [1:0]                    hc_status,
  output logic                          rd_err
);

  localparam int STAGES = 2;

  // vld_pipe[1]: stage 1 holds a request, vld_pipe[2]: response on c2
  logic [STAGES:1] vld_pipe;

  t_ccip_c0_ReqMmioHdr req_hdr;
  logic                acc;
  logic [6:0]          qw;       // 8-byte word index inside the 1 KB window

  assign req_hdr = rx_mmio_channel.hdr;
  assign acc     = rx_mmio_channel.mmioRdValid && (req_hdr.address[15:8] == 8'h0);
  assign qw      = req_hdr.address[7:1];

  t_hc_buffer bufs [HC_BUFFER_SIZE];
  for (genvar g = 0; g < HC_BUFFER_SIZE; g++) begin : g_buf
    assign bufs[g] = hc_buffer[96*g +: 96];
  end

  // ---------------- decode (stage 1 input) ----------------
  logic [63:0] dec_val;
  logic        dec_cnt;

  always_comb begin
    dec_val = '0;
    dec_cnt = 1'b0;
    case (qw)
      7'h00: dec_val = AFU_DFH;
      7'h01: dec_val = AFU_ID[63:0];
      7'h02: dec_val = AFU_ID[127:64];
      7'h20: dec_val = {62'b0, hc_status};
`ifdef HC_MMIO_RD_CNT_EN
      7'h21: dec_cnt = 1'b1;
`endif
      7'h22: dec_val = hc_dsm_base;
      7'h23: dec_val = {32'b0, hc_control};
      default: begin
        // buffer i: address at qword 0x24+2i, size at 0x25+2i
        for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
          if (int'(qw) == 36 + 2*i) dec_val = bufs[i].address;
          if (int'(qw) == 37 + 2*i) dec_val = {32'b0, bufs[i].size};
        end
      end
    endcase
  end

  // ---------------- stage 1 ----------------
  logic [8:0]  s1_tid;
  logic        s1_addr0;
  logic [1:0]  s1_len;
  logic [63:0] s1_val;
  logic        s1_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_tid   <= '0;
      s1_addr0 <= 1'b0;
      s1_len   <= '0;
      s1_val   <= '0;
      s1_cnt   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      if (acc) begin
        s1_tid   <= req_hdr.tid;
        s1_addr0 <= req_hdr.address[0];
        s1_len   <= req_hdr.length;
        s1_val   <= dec_val;
        s1_cnt   <= dec_cnt;
        if (req_hdr.length[1]) rd_err <= 1'b1;
      end
    end
  end

  // ---------------- optional response counter ----------------
`ifdef HC_MMIO_RD_CNT_EN
  logic [31:0] rsp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rsp_cnt <= '0;
    else if (vld_pipe[2]) rsp_cnt <= rsp_cnt + 32'd1;
  end
`endif

  // ---------------- stage 2 formatting ----------------
  logic [63:0] raw;
  logic [31:0] half;
  logic [63:0] fmt;

  always_comb begin
    raw = s1_val;
`ifdef HC_MMIO_RD_CNT_EN
    // Counter read is resolved here, not in stage 1. The response on c2 this
    // cycle is not in rsp_cnt yet, so it is added to keep every earlier
    // response in the value.
    if (s1_cnt) raw = {32'b0, rsp_cnt + {31'b0, vld_pipe[2]}};
`endif
    half = s1_addr0 ? raw[63:32] : raw[31:0];
    fmt  = '0;
    case (s1_len)
      2'd0:    fmt = {half, half};
      2'd1:    fmt = raw;
      default: fmt = '0;
    endcase
  end

  logic [8:0]  tx_tid;
  logic [63:0] tx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_tid  <= '0;
      tx_data <= '0;
    end else if (vld_pipe[1]) begin
      tx_tid  <= s1_tid;
      tx_data <= fmt;
    end
  end

  always_comb begin
    tx_mmio_channel             = '0;
    tx_mmio_channel.mmioRdValid = vld_pipe[2];
    tx_mmio_channel.hdr.tid     = tx_tid;
    tx_mmio_channel.data        = tx_data;
  end

  logic unused_rx;
  assign unused_rx = ^{rx_mmio_channel.data, rx_mmio_channel.rspValid,
                       rx_mmio_channel.mmioWrValid, req_hdr.rsvd, s1_cnt};

endmodule

// File: tb/tb_hc_mmio_rd_responder.sv
// ---------------------------------------------------------------------------
// tb_hc_mmio_rd_responder
//   Scoreboard bench. Each accepted request pushes its expected response,
//   computed by a reference model of the offset map, into a queue. A monitor
//   on the falling edge pops the queue and compares tid, data, latency and
//   rd_err. Directed cases come first, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_hc_mmio_rd_responder;
  import hc_mmio_rd_pkg::*;

  localparam logic [63:0]  DFH = 64'h1000_0100_0000_0000;
  localparam logic [127:0] AID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam int           NB  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  t_if_ccip_c0_Rx       rx;
  t_if_ccip_c2_Tx       tx;
  logic [63:0]          hc_dsm_base;
  logic [31:0]          hc_control;
  logic [NB*96-1:0]     hc_buffer;
  logic [1:0]           hc_status;
  logic                 rd_err;

  logic [63:0] b_addr [NB];
  logic [31:0] b_size [NB];

  always_comb begin
    hc_buffer = '0;
    for (int i = 0; i < NB; i++) hc_buffer[96*i +: 96] = {b_addr[i], b_size[i]};
  end

  hc_mmio_rd_responder #(.AFU_DFH(DFH), .AFU_ID(AID), .HC_BUFFER_SIZE(NB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_mmio_channel(rx), .tx_mmio_channel(tx),
    .hc_dsm_base(hc_dsm_base), .hc_control(hc_control), .hc_buffer(hc_buffer),
    .hc_status(hc_status), .rd_err(rd_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [8:0]  tid;
    logic [63:0] data;
    logic        bad;
  } exp_t;

  exp_t        sb [$];
  int          checks = 0;
  int          passes = 0;
  int unsigned model_cnt = 0;   // responses owed before the next accepted read
  logic        err_pushed = 1'b0;
  logic        err_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference map: byte offset -> 64-bit value, then length formatting.
  function automatic logic [63:0] ref_val(input logic [15:0] addr, input logic [1:0] len,
                                          input int unsigned cnt);
    int          off;
    int          i;
    logic [63:0] v;
    logic [31:0] h;
    off = int'(addr[15:1]) * 8;
    v   = '0;
    if      (off == 0)     v = DFH;
    else if (off == 8)     v = AID[63:0];
    else if (off == 16)    v = AID[127:64];
    else if (off == 'h100) v = {62'b0, hc_status};
`ifdef HC_MMIO_RD_CNT_EN
    else if (off == 'h108) v = {32'b0, cnt};
`endif
    else if (off == 'h110) v = hc_dsm_base;
    else if (off == 'h118) v = {32'b0, hc_control};
    else if (off >= 'h120 && off < 'h120 + 16*NB) begin
      i = (off - 'h120) / 16;
      if ((off - 'h120) % 16 == 0) v = b_addr[i];
      else                         v = {32'b0, b_size[i]};
    end
    if (cnt == 32'hFFFF_FFFF) v = v;  // no-op keeps cnt referenced in all builds
    case (len)
      2'd0: begin
        h = addr[0] ? v[63:32] : v[31:0];
        return {h, h};
      end
      2'd1:    return v;
      default: return 64'h0;
    endcase
  endfunction

  // Drive one request at a falling edge; valid stays high until idle().
  task automatic issue(input logic [15:0] addr, input logic [1:0] len, input logic [8:0] tid);
    exp_t e;
    rx.mmioRdValid     = 1'b1;
    rx.hdr.address     = addr;
    rx.hdr.length      = len;
    rx.hdr.tid         = tid;
    if (addr < 16'h100) begin
      e.cyc  = cyc + 2;
      e.tid  = tid;
      e.data = ref_val(addr, len, model_cnt);
      e.bad  = len[1];
      sb.push_back(e);
      model_cnt++;
      if (len[1]) err_pushed = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx.mmioRdValid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called right after a falling edge; reset lands mid low phase.
  task automatic do_reset(input int n);
    #2;
    rst_n = 1'b0;
    rx.mmioRdValid = 1'b0;
    sb.delete();
    model_cnt  = 0;
    err_pushed = 1'b0;
    err_seen   = 1'b0;
    repeat (n) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_regs();
    hc_dsm_base = {$urandom, $urandom};
    hc_control  = $urandom;
    hc_status   = 2'($urandom_range(0, 3));
    for (int i = 0; i < NB; i++) begin
      b_addr[i] = {$urandom, $urandom};
      b_size[i] = $urandom;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_out", {tx.mmioRdValid, tx.hdr.tid, rd_err, tx.data[52:0]}, 64'h0);
      check("reset_data", tx.data, 64'h0);
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++;
        $display("FAIL missing_rsp: got none expected tid %h at cycle %0d", e.tid, e.cyc);
      end
      if (tx.mmioRdValid) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_rsp: got tid %h data %h expected no response (cycle %0d)",
                   tx.hdr.tid, tx.data, cyc);
        end else begin
          e = sb.pop_front();
          check("latency", 64'(cyc), 64'(e.cyc));
          check("tid", 64'(tx.hdr.tid), 64'(e.tid));
          check("data", tx.data, e.data);
          if (e.bad) err_seen = 1'b1;
          if (err_seen)        check("rd_err_set", 64'(rd_err), 64'd1);
          else if (!err_pushed) check("rd_err_clr", 64'(rd_err), 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int picks [16] = '{'h00, 'h01, 'h02, 'h03, 'h04, 'h20, 'h21, 'h22,
                     'h23, 'h24, 'h25, 'h26, 'h27, 'h28, 'h29, 'h2A};

  initial begin
    logic [15:0] a;
    logic [1:0]  l;
    rx = '0;
    hc_dsm_base = '0; hc_control = '0; hc_status = '0;
    for (int i = 0; i < NB; i++) begin b_addr[i] = '0; b_size[i] = '0; end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // DFH, tid 5
    issue(16'h0000, 2'd1, 9'h05);
    idle(4);

    // DSM base 8B, then 4B high half replicated
    hc_dsm_base = 64'hDEAD_BEEF_0000_1000;
    issue(16'h0110 >> 2, 2'd1, 9'h10);
    issue((16'h0110 >> 2) + 16'd1, 2'd0, 9'h11);
    idle(4);

    // back-to-back: buffer[0].size, buffer[2].address, unmapped
    b_size[0] = 32'h0000_4000; b_addr[2] = 64'h0123_0000_ABCD_0040;
    issue(16'h0128 >> 2, 2'd1, 9'h1);
    issue(16'h0140 >> 2, 2'd1, 9'h2);
    issue(16'h01F8 >> 2, 2'd1, 9'h3);
    idle(4);

    // out-of-window request is dropped
    issue(16'h0100, 2'd1, 9'h7);
    idle(4);

    // unsupported length, then rd_err must hold on later responses
    issue(16'h0002, 2'd2, 9'h0AA);
    idle(3);
    issue(16'h0004, 2'd1, 9'h0AB);
    issue(16'h0005, 2'd0, 9'h0AC);
    idle(4);

    // reset while a request is in flight: no response
    issue(16'h0000, 2'd1, 9'h1FF);
    do_reset(3);
    idle(4);

    // counter: five reads, then two reads of 0x108
    for (int i = 0; i < 5; i++) issue(16'(i*2), 2'd1, 9'(i));
    issue(16'h0108 >> 2, 2'd1, 9'h20);
    issue(16'h0108 >> 2, 2'd1, 9'h21);
    idle(4);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      if (k == 300) begin
        issue(16'h0000, 2'd1, 9'h0);
        do_reset(2);
      end
      if ($urandom_range(0, 9) < 7) begin
        rand_regs();
        if ($urandom_range(0, 9) < 2) a = 16'($urandom);
        else a = 16'(picks[$urandom_range(0, 15)] * 2 + int'($urandom_range(0, 1)));
        l = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
        issue(a, l, 9'($urandom));
      end else begin
        idle(1);
      end
    end
    idle(6);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hc_mmio_rd_responder.md
Name: hc_mmio_rd_responder

Overview:
- CCI-P MMIO read responder for HardCloud AFUs.
- Accepts MMIO read requests on the c0 Rx channel and returns the AFU DFH, the AFU ID, and read-back copies of the HC DSM/control/buffer registers on the c2 Tx channel.
- It is the read-side counterpart of the HC MMIO write decode. It sits beside the write-decode register file and gets its register values from that file.
- Fixed two-stage pipeline; accepts back-to-back reads.

Parameters:
- AFU_DFH, 64'h1000_0100_0000_0000, value returned at byte offset 0x000
- AFU_ID, 128'h0, AFU GUID; [63:0] at 0x008, [127:64] at 0x010
- HC_BUFFER_SIZE, 3, number of buffer descriptors exposed

Ports:
- clk  in  1  AFU clock
- rst_n  in  1  asynchronous active-low reset
- rx_mmio_channel  in  t_if_ccip_c0_Rx  c0 Rx; uses mmioRdValid and hdr (t_ccip_c0_ReqMmioHdr)
- tx_mmio_channel  out  t_if_ccip_c2_Tx  c2 Tx; mmioRdValid, hdr.tid, data[63:0]
- hc_dsm_base  in  64  DSM base register value
- hc_control  in  32  control register value
- hc_buffer  in  HC_BUFFER_SIZE*96  packed t_hc_buffer array; entry i at [96*i +: 96]
- hc_status  in  2  {error, done}
- rd_err  out  1  sticky: unsupported read length seen

Behaviour:
- Reset: tx_mmio_channel.mmioRdValid=0, hdr=0, data=0. rd_err=0. Both pipeline valid bits cleared.
- Reset asserted mid-operation: in-flight requests are dropped and no response is issued.
- Request acceptance:
  - A request is accepted in cycle N when rx_mmio_channel.mmioRdValid=1 and hdr.address < 'h100 (4-byte word address).
  - Other requests are ignored and get no response.
- Stage 1 (edge ending N):
  - Register tid, the word address, and length.
  - Register the decoded 64-bit value, using the input register values present in cycle N.
  - A write that lands in the same cycle is not reflected; the read returns the pre-write value.
- Stage 2 (edge ending N+1):
  - Drive mmioRdValid=1, hdr.tid=captured tid, data=formatted value.
  - The response is valid during cycle N+2. Latency is exactly 2 cycles.
- Throughput: one request per cycle with no bubbles. c2 has no backpressure.
- Decode, by 8-byte-aligned byte offset = {address[15:1],1'b0}<<2:
  - 0x000: AFU_DFH
  - 0x008: AFU_ID[63:0]
  - 0x010: AFU_ID[127:64]
  - 0x018, 0x020: 0
  - 0x100: {62'b0, hc_status}
  - 0x110: hc_dsm_base
  - 0x118: {32'b0, hc_control}
  - 0x120+0x10*i, i<HC_BUFFER_SIZE: buffer[i].address
  - 0x128+0x10*i: {32'b0, buffer[i].size}
  - All other offsets: 64'h0
- Length encoding:
  - 0 (4B): select the low half if address[0]=0, the high half if 1. Replicate the selected half into data[31:0] and data[63:32].
  - 1 (8B): return the full 64-bit value. address[0] is ignored.
  - 2 or 3: respond with data=0 and set rd_err. rd_err clears only on reset.
- Mid-pipeline reads: requests in stage 1 and stage 2 each complete independently. Responses leave in request order.

Optional Feature:
- HC_MMIO_RD_CNT_EN defined:
  - Add a 32-bit counter of issued responses, incremented on each cycle where tx mmioRdValid=1.
  - The counter wraps from 32'hFFFF_FFFF to 0 and resets to 0.
  - It is readable at offset 0x108 as {32'b0, count}. The value read is the count before that read's own response.
- HC_MMIO_RD_CNT_EN undefined: offset 0x108 decodes as unmapped and returns 0. No counter flops are built.

Test Plan:
- 8B read at word address 0x0 with tid=9'h05 -> cycle N+2: mmioRdValid=1, tid=5, data=AFU_DFH. No other valid cycles.
- hc_dsm_base=64'hDEAD_BEEF_0000_1000, 8B read at 0x110>>2 -> data=64'hDEAD_BEEF_0000_1000. 4B read at (0x110>>2)+1 -> data=64'hDEAD_BEEF_DEAD_BEEF.
- Back-to-back reads on 3 consecutive cycles: buffer[0].size at 0x128, buffer[2].address at 0x140, unmapped 0x1F8, tids 1/2/3 -> responses on 3 consecutive cycles, in order, with the correct values; the unmapped read returns 0.
- Read with length=2 -> data=0 and tid echoed; rd_err=1 from the next cycle and stays 1 until rst_n is asserted.
- Request issued, then rst_n pulsed low at cycle N+1 -> no response; outputs are 0 while in reset.
- HC_MMIO_RD_CNT_EN: after 5 reads, a read at 0x108 returns 5 and a following read returns 6. Without the macro, 0x108 returns 0.
